// File: rtl/test_pulse_train_gen_pkg.sv
// test_pulse_pkg: register map, CTRL bits, CFG field helpers and FSM states for test_pulse_train_gen
package test_pulse_pkg;

    localparam logic [3:0] ADDR_CTRL          = 4'd0;
    localparam logic [3:0] ADDR_STATUS        = 4'd1;
    localparam logic [3:0] ADDR_PERIOD        = 4'd2;
    localparam logic [3:0] ADDR_REPEAT        = 4'd3;
    localparam logic [3:0] ADDR_START_CFG     = 4'd4;
    localparam logic [3:0] ADDR_STOP_CFG_BASE = 4'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CONT  = 2;

    localparam int CFG_EN_BIT = 31;

    function automatic int cfg_len_lsb(input int delay_w);
        return delay_w;
    endfunction

    function automatic logic [31:0] cfg_mask(input int delay_w, input int len_w);
        logic [31:0] m;
        m = '0;
        m[CFG_EN_BIT] = 1'b1;
        for (int b = 0; b < 31; b++)
            if (b < delay_w + len_w) m[b] = 1'b1;
        return m;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/test_pulse_train_gen_pulse_channel.sv
// pulse_channel: one delayed, fixed-length test pulse per strobe
//   avmm_clk, avmm_reset : clock, synchronous active-high reset
//   strobe               : shot strobe; latches en/delay/len and restarts the channel
//   clr                  : abort, forces the channel silent
//   en, delay, len       : live CFG fields from the register file
//   pulse                : registered channel output
//   active               : channel is in its delay or pulse phase
module pulse_channel
    import test_pulse_pkg::*;
#(
    parameter int DELAY_W = 16,
    parameter int LEN_W   = 15
) (
    input  logic               avmm_clk,
    input  logic               avmm_reset,
    input  logic               strobe,
    input  logic               clr,
    input  logic               en,
    input  logic [DELAY_W-1:0] delay,
    input  logic [LEN_W-1:0]   len,
    output logic               pulse,
    output logic               active
);

    logic [DELAY_W-1:0] dly_cnt;
    logic [LEN_W-1:0]   len_cnt, sh_len;
    logic               dly_act, fire;

    assign fire   = en && len != '0;
    assign active = dly_act | pulse;

    // pulse is set on the edge ending cycle t0+delay, so it is high from t0+1+delay for len cycles
    always_ff @(posedge avmm_clk) begin
        if (avmm_reset || clr) begin
            dly_act <= 1'b0;
            pulse   <= 1'b0;
            dly_cnt <= '0;
            len_cnt <= '0;
            sh_len  <= '0;
        end else if (strobe) begin
            sh_len  <= len;
            dly_cnt <= delay;
            len_cnt <= len;
            dly_act <= fire && delay != '0;
            pulse   <= fire && delay == '0;
        end else if (dly_act) begin
            dly_cnt <= dly_cnt - DELAY_W'(1);
            if (dly_cnt == DELAY_W'(1)) begin
                dly_act <= 1'b0;
                pulse   <= 1'b1;
                len_cnt <= sh_len;
            end
        end else if (pulse) begin
            len_cnt <= len_cnt - LEN_W'(1);
            if (len_cnt == LEN_W'(1)) pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/test_pulse_train_gen.sv
// test_pulse_train_gen: Avalon-MM programmable train of TDC start/stop test pulses
//   avmm_clk, avmm_reset        : clock, synchronous active-high reset
//   avmm_cs/addr/write/read     : register access, writedata in, readdata out (1-cycle latency)
//   start_pulse                 : start channel output
//   stop_pulse, stop_pulse_vec  : OR of stop channels, per-channel stop outputs
//   busy, done                  : train in progress, one-cycle completion pulse
module test_pulse_train_gen
    import test_pulse_pkg::*;
#(
    parameter int NUM_STOP = 5,
    parameter int DELAY_W  = 16,
    parameter int LEN_W    = 15,
    parameter int CNT_W    = 16
) (
    input  logic                avmm_clk,
    input  logic                avmm_reset,
    input  logic                avmm_cs,
    input  logic [3:0]          avmm_addr,
    input  logic                avmm_write,
    input  logic [31:0]         avmm_writedata,
    input  logic                avmm_read,
    output logic [31:0]         avmm_readdata,
    output logic                start_pulse,
    output logic                stop_pulse,
    output logic [NUM_STOP-1:0] stop_pulse_vec,
    output logic                busy,
    output logic                done
);

    localparam int          LEN_LSB  = cfg_len_lsb(DELAY_W);
    localparam logic [31:0] CFG_MASK = cfg_mask(DELAY_W, LEN_W);

    logic              wr, rd, start_wr, abort_wr;
    logic              cont;
    logic [CNT_W-1:0]  period, rpt, pcnt, shots, per_m1, rpt_eff;
    logic [31:0]       cfg [NUM_STOP+1];
    logic [31:0]       rd_mux;
    state_t            state, state_n;
    logic              strobe, clr, done_set, hit, more, any_act;
    logic [NUM_STOP:0] ch_out, ch_act;

    assign wr       = avmm_cs && avmm_write;
    assign rd       = avmm_cs && avmm_read && !avmm_write;
    assign start_wr = wr && avmm_addr == ADDR_CTRL && avmm_writedata[CTRL_START];
    assign abort_wr = wr && avmm_addr == ADDR_CTRL && avmm_writedata[CTRL_ABORT];

    always_ff @(posedge avmm_clk) begin
        if (avmm_reset) begin
            cont   <= 1'b0;
            period <= '0;
            rpt    <= '0;
            for (int k = 0; k <= NUM_STOP; k++) cfg[k] <= '0;
        end else if (wr) begin
            if (avmm_addr == ADDR_CTRL)   cont   <= avmm_writedata[CTRL_CONT];
            if (avmm_addr == ADDR_PERIOD) period <= avmm_writedata[CNT_W-1:0];
            if (avmm_addr == ADDR_REPEAT) rpt    <= avmm_writedata[CNT_W-1:0];
            for (int k = 0; k <= NUM_STOP; k++)
                if (avmm_addr == 4'(ADDR_START_CFG + k)) cfg[k] <= avmm_writedata & CFG_MASK;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (avmm_addr == ADDR_CTRL) rd_mux[CTRL_CONT] = cont;
        if (avmm_addr == ADDR_STATUS) begin
            rd_mux[0]          = busy;
            rd_mux[16 +: CNT_W] = shots;
        end
        if (avmm_addr == ADDR_PERIOD) rd_mux[CNT_W-1:0] = period;
        if (avmm_addr == ADDR_REPEAT) rd_mux[CNT_W-1:0] = rpt;
        for (int k = 0; k <= NUM_STOP; k++)
            if (avmm_addr == 4'(ADDR_START_CFG + k)) rd_mux = cfg[k];
    end

    always_ff @(posedge avmm_clk) begin
        if (avmm_reset) avmm_readdata <= '0;
        else if (rd)    avmm_readdata <= rd_mux;
    end

    assign per_m1  = (period == '0) ? '0 : period - CNT_W'(1);
    assign rpt_eff = (rpt == '0) ? CNT_W'(1) : rpt;
    // >= rather than == so a PERIOD shrunk mid-train cannot let pcnt run past and wrap
    assign hit     = pcnt >= per_m1;
    assign more    = cont || shots < rpt_eff;
    assign any_act = |ch_act;

    always_ff @(posedge avmm_clk) begin
        if (avmm_reset) state <= IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_wr) state_n = RUN;
            RUN:     if (abort_wr) state_n = IDLE;
                     else if (hit && !more) state_n = DONE;
            DONE:    if (!any_act) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        strobe   = (state == IDLE && start_wr) || (state == RUN && !abort_wr && hit && more);
        clr      = state == RUN && abort_wr;
        done_set = state == DONE && !any_act;
    end

    always_ff @(posedge avmm_clk) begin
        if (avmm_reset) begin
            pcnt  <= '0;
            shots <= '0;
            done  <= 1'b0;
        end else begin
            done <= done_set;
            pcnt <= strobe ? '0 : (state == RUN && !hit) ? pcnt + CNT_W'(1) : pcnt;
            if (strobe) shots <= (state == IDLE) ? CNT_W'(1) : (&shots) ? shots : shots + CNT_W'(1);
        end
    end

    assign busy = state != IDLE;

    // channel 0 is the start channel, channels 1..NUM_STOP are the stop channels
    for (genvar i = 0; i <= NUM_STOP; i++) begin : g_ch
        pulse_channel #(
            .DELAY_W(DELAY_W),
            .LEN_W  (LEN_W)
        ) u_ch (
            .avmm_clk  (avmm_clk),
            .avmm_reset(avmm_reset),
            .strobe    (strobe),
            .clr       (clr),
            .en        (cfg[i][CFG_EN_BIT]),
            .delay     (cfg[i][DELAY_W-1:0]),
            .len       (cfg[i][LEN_LSB +: LEN_W]),
            .pulse     (ch_out[i]),
            .active    (ch_act[i])
        );
    end

    assign start_pulse    = ch_out[0];
    assign stop_pulse_vec = ch_out[NUM_STOP:1];
    assign stop_pulse     = |stop_pulse_vec;

endmodule

// File: tb/tb_test_pulse_train_gen.sv
// tb_test_pulse_train_gen: directed, table-driven self-checking bench for test_pulse_train_gen
module tb_test_pulse_train_gen;

    localparam int NS = 5;

    logic          avmm_clk = 1'b0;
    logic          avmm_reset, avmm_cs, avmm_write, avmm_read;
    logic [3:0]    avmm_addr;
    logic [31:0]   avmm_writedata, avmm_readdata;
    logic          start_pulse, stop_pulse, busy, done;
    logic [NS-1:0] stop_pulse_vec;

    int n_chk = 0;
    int n_fail = 0;

    logic [127:0] tr_start, tr_stop, tr_done, tr_busy;
    logic [127:0] tr_vec [NS];

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } rw_t;

    rw_t tbl [13];

    test_pulse_train_gen #(.NUM_STOP(NS)) dut (
        .avmm_clk      (avmm_clk),
        .avmm_reset    (avmm_reset),
        .avmm_cs       (avmm_cs),
        .avmm_addr     (avmm_addr),
        .avmm_write    (avmm_write),
        .avmm_writedata(avmm_writedata),
        .avmm_read     (avmm_read),
        .avmm_readdata (avmm_readdata),
        .start_pulse   (start_pulse),
        .stop_pulse    (stop_pulse),
        .stop_pulse_vec(stop_pulse_vec),
        .busy          (busy),
        .done          (done)
    );

    always #5 avmm_clk = ~avmm_clk;

    task automatic tick;
        @(posedge avmm_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] cw(input int d, input int l, input bit en);
        return {en, 31'(0)} | (32'(l) << 16) | 32'(d);
    endfunction

    task automatic bus_idle;
        avmm_cs = 1'b0;
        avmm_write = 1'b0;
        avmm_read = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        avmm_cs = 1'b1;
        avmm_write = 1'b1;
        avmm_addr = a;
        avmm_writedata = d;
        tick;
        bus_idle;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        avmm_cs = 1'b1;
        avmm_read = 1'b1;
        avmm_addr = a;
        tick;
        bus_idle;
        d = avmm_readdata;
    endtask

    task automatic do_reset;
        bus_idle;
        avmm_reset = 1'b1;
        tick;
        tick;
        avmm_reset = 1'b0;
        tick;
    endtask

    task automatic ctrl_drive(input logic [31:0] d);
        avmm_cs = 1'b1;
        avmm_write = 1'b1;
        avmm_addr = 4'd0;
        avmm_writedata = d;
    endtask

    // CTRL write d0 in cycle t0, then records cycles t0+1..t0+n; optional CTRL writes at t0+k1, t0+k2
    task automatic go(input int n, input logic [31:0] d0, input int k1, input logic [31:0] d1,
                      input int k2, input logic [31:0] d2);
        tr_start = '0;
        tr_stop = '0;
        tr_done = '0;
        tr_busy = '0;
        for (int j = 0; j < NS; j++) tr_vec[j] = '0;
        ctrl_drive(d0);
        for (int k = 1; k <= n; k++) begin
            tick;
            if (k == k1) ctrl_drive(d1);
            else if (k == k2) ctrl_drive(d2);
            else bus_idle;
            tr_start[k] = start_pulse;
            tr_stop[k] = stop_pulse;
            tr_done[k] = done;
            tr_busy[k] = busy;
            for (int j = 0; j < NS; j++) tr_vec[j][k] = stop_pulse_vec[j];
        end
        bus_idle;
    endtask

    initial begin
        logic [31:0] rdv;
        logic [127:0] e;

        tbl[0]  = '{4'd2,  32'hFFFF_1234, 32'h0000_1234};
        tbl[1]  = '{4'd3,  32'hABCD_0005, 32'h0000_0005};
        tbl[2]  = '{4'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[3]  = '{4'd5,  32'h8001_0003, 32'h8001_0003};
        tbl[4]  = '{4'd6,  32'h7FFF_FFFF, 32'h7FFF_FFFF};
        tbl[5]  = '{4'd7,  32'h1234_5678, 32'h1234_5678};
        tbl[6]  = '{4'd8,  32'h8000_0000, 32'h8000_0000};
        tbl[7]  = '{4'd9,  32'h0000_FFFF, 32'h0000_FFFF};
        tbl[8]  = '{4'd0,  32'h0000_0004, 32'h0000_0004};
        tbl[9]  = '{4'd0,  32'hFFFF_FFF8, 32'h0000_0000};
        tbl[10] = '{4'd15, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[11] = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0000};
        tbl[12] = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0000};

        avmm_addr = '0;
        avmm_writedata = '0;
        do_reset;
        chk("reset_outputs", {busy, done, start_pulse, stop_pulse, stop_pulse_vec, avmm_readdata}, '0);

        for (int i = 0; i < 13; i++) begin
            wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, rdv);
            chk($sformatf("readback_addr%0d", tbl[i].addr), rdv, tbl[i].exp);
        end

        rd(4'd2, rdv);
        chk("period_before_collision", rdv, 32'h0000_1234);
        avmm_cs = 1'b1;
        avmm_write = 1'b1;
        avmm_read = 1'b1;
        avmm_addr = 4'd3;
        avmm_writedata = 32'd7;
        tick;
        bus_idle;
        chk("collision_readdata_held", avmm_readdata, 32'h0000_1234);
        rd(4'd3, rdv);
        chk("collision_write_taken", rdv, 32'd7);

        // single shot
        do_reset;
        wr(4'd4, cw(3, 2, 1));
        wr(4'd5, cw(10, 1, 1));
        go(30, 32'h1, 0, 0, 0, 0);
        chk("single_start", tr_start, 128'h30);
        chk("single_stop", tr_stop, 128'h800);
        chk("single_done_count", 128'($countones(tr_done)), 128'd1);
        chk("single_busy_after", 128'(busy), 128'd0);
        rd(4'd1, rdv);
        chk("single_status", rdv, 32'h0001_0000);

        // train of 3
        do_reset;
        wr(4'd2, 32'd20);
        wr(4'd3, 32'd3);
        wr(4'd4, cw(0, 1, 1));
        go(80, 32'h1, 0, 0, 0, 0);
        e = '0;
        e[1] = 1'b1;
        e[21] = 1'b1;
        e[41] = 1'b1;
        chk("train_start", tr_start, e);
        chk("train_done_count", 128'($countones(tr_done)), 128'd1);
        rd(4'd1, rdv);
        chk("train_status", rdv, 32'h0003_0000);

        // multi-stop with channel 2 disabled
        do_reset;
        for (int j = 0; j < NS; j++) wr(4'(5 + j), cw(5 + j, 1, j != 2));
        go(20, 32'h1, 0, 0, 0, 0);
        for (int j = 0; j < NS; j++) begin
            e = '0;
            if (j != 2) e[6 + j] = 1'b1;
            chk($sformatf("multi_vec%0d", j), tr_vec[j], e);
        end
        e = '0;
        e[6] = 1'b1;
        e[7] = 1'b1;
        e[9] = 1'b1;
        e[10] = 1'b1;
        chk("multi_or", tr_stop, e);
        chk("multi_start_silent", tr_start, '0);

        // truncation and restart
        do_reset;
        wr(4'd2, 32'd4);
        wr(4'd3, 32'd2);
        wr(4'd4, cw(2, 10, 1));
        go(30, 32'h1, 0, 0, 0, 0);
        e = '0;
        e[3] = 1'b1;
        e[4] = 1'b1;
        for (int c = 7; c <= 16; c++) e[c] = 1'b1;
        chk("restart_start", tr_start, e);
        chk("restart_done_count", 128'($countones(tr_done)), 128'd1);
        chk("restart_busy_after", 128'(busy), 128'd0);

        // continuous, START ignored in RUN, ABORT mid-pulse
        do_reset;
        wr(4'd0, 32'h4);
        wr(4'd2, 32'd8);
        wr(4'd4, cw(0, 4, 1));
        go(45, 32'h5, 3, 32'h5, 34, 32'h2);
        e = '0;
        for (int s = 0; s < 4; s++)
            for (int c = 1; c <= 4; c++) e[8 * s + c] = 1'b1;
        e[33] = 1'b1;
        e[34] = 1'b1;
        chk("cont_start", tr_start, e);
        chk("cont_no_done", 128'($countones(tr_done)), 128'd0);
        chk("cont_busy_34_35", 128'({tr_busy[34], tr_busy[35], tr_busy[40]}), 128'b100);
        rd(4'd1, rdv);
        chk("cont_status", rdv, 32'h0005_0000);

        // reset mid-pulse
        wr(4'd4, cw(1, 8, 1));
        ctrl_drive(32'h1);
        tick;
        bus_idle;
        tick;
        chk("midpulse_high", 128'(start_pulse), 128'd1);
        avmm_reset = 1'b1;
        tick;
        chk("midpulse_reset_low", 128'({start_pulse, busy, done}), 128'd0);
        avmm_reset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), rdv);
            chk($sformatf("post_reset_addr%0d", a), rdv, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/test_pulse_train_gen.md
Name: test_pulse_train_gen

Overview:
Parametrised successor of the single-shot test pulse generator. An Avalon-MM slave programs one start channel and NUM_STOP stop channels, each with its own delay, length and enable. The block then fires a train of shots at a programmable period, either a set number of shots or continuously. It drives the rangefinder TDC start/stop test inputs, and exposes busy/done status and a shot counter for self-test firmware.

Parameters:
NUM_STOP, 5, number of stop channels (1..11).
DELAY_W, 16, delay field width in cycles (DELAY_W+LEN_W <= 31).
LEN_W, 15, pulse length field width in cycles.
CNT_W, 16, width of the period, repeat and shot counters (<= 16).

Ports:
avmm_clk  in  1  clock
avmm_reset  in  1  synchronous, active-high reset
avmm_cs  in  1  chip select
avmm_addr  in  4  word address
avmm_write  in  1  write strobe
avmm_writedata  in  32  write data
avmm_read  in  1  read strobe
avmm_readdata  out  32  read data, registered
start_pulse  out  1  start channel output
stop_pulse  out  1  OR of all stop channel outputs
stop_pulse_vec  out  NUM_STOP  per-channel stop outputs
busy  out  1  train in progress
done  out  1  one-cycle pulse at train completion

Behaviour:
- Clock is avmm_clk; reset is synchronous and active-high.
- Reset clears all registers, readdata, outputs, busy, done and counters, and puts the FSM in IDLE. This applies mid-train too: outputs go low on the next edge.
- Register map:
  - 0 CTRL: bit0 START (write-1 strobe, reads 0); bit1 ABORT (write-1 strobe, reads 0); bit2 CONT (stored).
  - 1 STATUS (RO): bit0 busy; [31:16] shots fired in the current or last train.
  - 2 PERIOD: [CNT_W-1:0].
  - 3 REPEAT: [CNT_W-1:0].
  - 4 START_CFG.
  - 5..4+NUM_STOP STOPn_CFG.
  - CFG word layout: [DELAY_W-1:0] delay, [DELAY_W+LEN_W-1:DELAY_W] len, [31] enable.
  - Unused bits of any register read 0. Unmapped addresses: writes ignored, reads return 0.
- Bus access:
  - Read latency is 1 cycle. readdata holds its value when no read is in progress.
  - If write and read are both asserted, the write wins and readdata is unchanged.
- FSM states:
  - IDLE:
    - START -> RUN. A shot strobe is issued in the same cycle as the START write and shot count is set to 1.
  - RUN:
    - The period counter counts cycles since the last strobe.
    - When it reaches max(PERIOD,1)-1:
      - If CONT is set, or shots < max(REPEAT,1): issue the next strobe and increment shots, saturating at all-ones.
      - Otherwise -> DONE.
    - ABORT -> IDLE next cycle; all outputs forced low and done is not pulsed.
    - START while in RUN is ignored.
  - DONE:
    - Waits until all channel outputs are low, then pulses done for 1 cycle -> IDLE.
- busy = (state != IDLE).
- Per-channel behaviour at each strobe (cycle t0):
  - The channel latches its CFG into a shadow register, so register writes during RUN apply from the next strobe.
  - If enable=1 and len>0, the output is high for cycles t0+1+delay through t0+delay+len inclusive. Otherwise the channel is silent for that shot.
  - A strobe arriving while a channel is still in delay or pulse restarts that channel: its output drops on the next cycle and re-evaluates with the new shadow values.
- Counters never wrap. The delay and length counters are sized exactly to their fields.
- All outputs are registered, with no combinational path from the bus to the pins.

Decomposition:
- Package test_pulse_pkg holds:
  - register address constants (CTRL, STATUS, PERIOD, REPEAT, START_CFG, STOP_CFG_BASE);
  - CTRL bit indices;
  - CFG field offset/width functions of DELAY_W/LEN_W;
  - the FSM state enum {IDLE, RUN, DONE}.
- Sub-module pulse_channel (params DELAY_W, LEN_W) contains the shadow CFG, delay/length counters and registered output. It is instantiated 1+NUM_STOP times with a generate loop.

Test Plan:
- Single shot: START_CFG delay=3 len=2 en=1; STOP0 delay=10 len=1 en=1; REPEAT=0; write START at t0 -> start_pulse high at t0+4..t0+5, stop_pulse high at t0+11 only, done pulses once, STATUS shots=1, busy low afterward.
- Train: PERIOD=20, REPEAT=3, START delay=0 len=1 -> start_pulse high at t0+1, t0+21, t0+41; no 4th pulse; STATUS[31:16]=3.
- Multi-stop OR and disable: NUM_STOP=5; STOP0..4 delays 5,6,7,8,9, len=1; STOP2 en=0 -> stop_pulse_vec shows 4 single pulses, bit2 silent; stop_pulse high at t0+6,7,9,10.
- Truncation/restart: PERIOD=4, START delay=2 len=10, REPEAT=2 -> pulse starts t0+3, drops at t0+5, restarts at t0+7, ends t0+16; then done.
- Continuous + abort: CONT=1, PERIOD=8, run 5 shots, write ABORT -> all outputs low next cycle, busy=0, no done pulse; START during RUN earlier ignored (shot spacing stays 8).
- Reset mid-pulse and register readback: assert avmm_reset while start_pulse is high -> low next edge, all registers read 0. Write/read each CFG -> readback exact with 1-cycle latency; address 15 reads 0.
